// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the mem_arb video/CPU dual-port RAM arbiter.
package mem_arb_pkg;

  localparam int unsigned MAXWAIT_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    VID  = 2'd1,
    CPU  = 2'd2
  } owner_t;

endpackage

// File: rtl/mem_arb_wbuf.sv
// One-entry CPU write buffer driving the RAM write port, with an address
// compare against the buffered entry for read forwarding.
module mem_arb_wbuf
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW = 14
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          wreq,
  input  logic [AW-1:0] wa,
  input  logic [7:0]    d,
  output logic          wack,
  output logic          ram_w2,
  output logic [AW-1:0] ram_a2,
  output logic [7:0]    ram_d2,
  input  logic [AW-1:0] cmp_a,
  output logic          hit,
  output logic [7:0]    hit_d
);

  logic          wb_full;
  logic [AW-1:0] wb_a;
  logic [7:0]    wb_d;

  // The entry always drains while full, so a new write is accepted every cycle.
  assign ram_w2 = wb_full;
  assign ram_a2 = wb_a;
  assign ram_d2 = wb_d;
  assign wack   = reset & wreq & (~wb_full | ram_w2);

  assign hit    = wb_full & (wb_a == cmp_a);
  assign hit_d  = wb_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wb_full <= 1'b0;
      wb_a    <= '0;
      wb_d    <= '0;
    end else if (wack) begin
      wb_full <= 1'b1;
      wb_a    <= wa;
      wb_d    <= d;
    end else begin
      wb_full <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_arb.sv
// Video/CPU arbiter for an external dual-port RAM: read port arbitrated with
// CPU anti-starvation, write port fed by a one-entry buffer.
// Optional read forwarding from the write buffer: define MEM_ARB_FWD_EN.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW      = 14,
  parameter int unsigned MAXWAIT = MAXWAIT_DEF
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          v_req,
  input  logic [AW-1:0] v_a,
  output logic          v_ack,
  output logic          v_valid,
  output logic [7:0]    v_q,
  input  logic          c_rreq,
  input  logic [AW-1:0] c_ra,
  output logic          c_rack,
  output logic          c_valid,
  output logic [7:0]    c_q,
  input  logic          c_wreq,
  input  logic [AW-1:0] c_wa,
  input  logic [7:0]    c_d,
  output logic          c_wack,
  output logic [AW-1:0] ram_a1,
  input  logic [7:0]    ram_q1,
  output logic [AW-1:0] ram_a2,
  output logic [7:0]    ram_d2,
  output logic          ram_w2
);

  owner_t     owner, owner_nx;
  logic [3:0] wait_cnt;
  logic       cpu_win, vid_win;
  logic [7:0] v_hold, c_hold, c_rd;
  logic       hit;
  logic [7:0] hit_d;

  // Grants are gated by reset so every output reads zero while reset is low.
  always_comb begin
    cpu_win = reset & c_rreq & (~v_req | (wait_cnt == 4'(MAXWAIT)));
    vid_win = reset & v_req & ~cpu_win;
  end

  assign v_ack  = vid_win;
  assign c_rack = cpu_win;
  assign ram_a1 = !reset ? '0 : (cpu_win ? c_ra : v_a);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) owner <= IDLE;
    else        owner <= owner_nx;
  end

  always_comb begin
    owner_nx = IDLE;
    if (cpu_win)      owner_nx = CPU;
    else if (vid_win) owner_nx = VID;
  end

  always_comb begin
    v_valid = (owner == VID);
    c_valid = (owner == CPU);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (c_rreq && !cpu_win) begin
      if (wait_cnt != 4'(MAXWAIT)) wait_cnt <= wait_cnt + 4'd1;
    end else begin
      wait_cnt <= '0;
    end
  end

  mem_arb_wbuf #(.AW(AW)) u_wbuf (
    .clock  (clock),
    .reset  (reset),
    .wreq   (c_wreq),
    .wa     (c_wa),
    .d      (c_d),
    .wack   (c_wack),
    .ram_w2 (ram_w2),
    .ram_a2 (ram_a2),
    .ram_d2 (ram_d2),
    .cmp_a  (c_ra),
    .hit    (hit),
    .hit_d  (hit_d)
  );

`ifdef MEM_ARB_FWD_EN
  logic       fwd_hit;
  logic [7:0] fwd_d;

  // Buffered data is captured at grant time; the RAM read of the same cycle is stale.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fwd_hit <= 1'b0;
      fwd_d   <= '0;
    end else begin
      fwd_hit <= cpu_win & hit;
      fwd_d   <= hit_d;
    end
  end

  assign c_rd = fwd_hit ? fwd_d : ram_q1;
`else
  logic unused_fwd;
  assign unused_fwd = ^{hit, hit_d};
  assign c_rd       = ram_q1;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      v_hold <= '0;
      c_hold <= '0;
    end else begin
      if (v_valid) v_hold <= ram_q1;
      if (c_valid) c_hold <= c_rd;
    end
  end

  assign v_q = v_valid ? ram_q1 : v_hold;
  assign c_q = c_valid ? c_rd : c_hold;

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter AW, default 14: address width of the shared dual-port RAM (2^AW bytes).
REQ-002 Parameter MAXWAIT, default 4: cycles a pending CPU read may be denied before it gains priority; range 1..15.
REQ-003 clock  input  1  single clock for all logic; RAM ports run on this clock.
REQ-004 reset  input  1  asynchronous, active-low.
REQ-005 v_req  input  1  video read request; held until v_ack.
REQ-006 v_a  input  AW  video read address, stable while v_req is high.
REQ-007 v_ack  output  1  video request granted this cycle.
REQ-008 v_valid  output  1  v_q holds the granted video data.
REQ-009 v_q  output  8  video read data.
REQ-010 c_rreq  input  1  CPU read request; held until c_rack.
REQ-011 c_ra  input  AW  CPU read address.
REQ-012 c_rack  output  1  CPU read granted this cycle.
REQ-013 c_valid  output  1  c_q holds the granted CPU data.
REQ-014 c_q  output  8  CPU read data.
REQ-015 c_wreq  input  1  CPU write request.
REQ-016 c_wa  input  AW  CPU write address.
REQ-017 c_d  input  8  CPU write data.
REQ-018 c_wack  output  1  write accepted this cycle.
REQ-019 ram_a1  output  AW  RAM read-port address.
REQ-020 ram_q1  input  8  RAM read data, one clock after ram_a1.
REQ-021 ram_a2, ram_d2, ram_w2  output  AW/8/1  RAM write-port address, data and enable.

Function
REQ-022 Read-port arbitration is evaluated every cycle; at most one of v_ack and c_rack is high.
- Default priority: video.
- CPU wins when c_rreq is high and either v_req is low or wait_cnt equals MAXWAIT.
REQ-023 wait_cnt (4 bits):
- increments each cycle c_rreq is high without c_rack;
- clears on c_rack or when c_rreq is low;
- saturates at MAXWAIT.
REQ-024 ram_a1 is driven combinationally with the winner's address, or with v_a when idle.
REQ-025 The owner register (IDLE/VID/CPU) captures the winner at each grant and returns to IDLE when there is none.
REQ-026 Read latency: a grant in cycle N produces a one-cycle v_valid/c_valid pulse in cycle N+1, steered by owner.
- v_q/c_q equal ram_q1 in that cycle and hold their last value otherwise.
REQ-027 Back-to-back grants are allowed every cycle; there are no bubbles.
REQ-028 Write buffer: one entry (wb_full, wb_a, wb_d).
- c_wack = c_wreq & (~wb_full | ram_w2).
- An accepted write loads the buffer.
REQ-029 ram_w2 = wb_full; ram_a2/ram_d2 = wb_a/wb_d; the entry drains in the same cycle ram_w2 is high.
- Write latency is one cycle, so one write is sustained per cycle.
REQ-030 A simultaneous drain and accept reloads the buffer; wb_full stays high.
REQ-031 Address wrap-around is the natural AW-bit modulo; no range checking is performed.

Reset
REQ-032 Reset asserted (any time, including mid-transfer):
- v_ack, c_rack, v_valid, c_valid, c_wack, ram_w2 = 0;
- v_q, c_q = 8'h00; ram_a1, ram_a2 = 0; ram_d2 = 8'h00;
- owner = IDLE; wait_cnt = 0; wb_full = 0.
- Any pending buffered write is discarded.
REQ-033 Arbitration resumes on the first clock edge after reset deassertion; requesters re-present their requests.

Configuration
REQ-034 Macro MEM_ARB_FWD_EN defined:
- A CPU read granted in cycle N whose address equals wb_a while wb_full is high returns wb_d in cycle N+1 instead of ram_q1.
- The forwarded data and address are captured in cycle N.
REQ-035 MEM_ARB_FWD_EN undefined: c_q always equals ram_q1; read-after-buffered-write returns pre-write data.

Structure
REQ-036 Package mem_arb_pkg holds the owner state enum (IDLE, VID, CPU) and the MAXWAIT default constant.
REQ-037 Sub-module mem_arb_wbuf implements the one-entry write buffer, including forwarding compare outputs.
REQ-038 The RAM itself is external; mem_arb instantiates no memory.

Verification
REQ-039 Scenario: v_req only, v_a=0x0100, RAM[0x0100]=0x5A -> v_ack in cycle N, v_valid with v_q=0x5A in N+1.
REQ-040 Scenario: v_req and c_rreq held continuously, MAXWAIT=4 -> c_rack in the 5th cycle; video acked in the other cycles; no double ack.
REQ-041 Scenario: c_wreq every cycle for 8 cycles, addresses 0x10..0x17 -> c_wack high every cycle; ram_w2 for 8 cycles with matching address and data one cycle later.
REQ-042 Scenario: write 0x33 to 0x0020, then a CPU read of 0x0020 granted in the next cycle -> c_q=0x33 with MEM_ARB_FWD_EN defined; old RAM value without it.
REQ-043 Scenario: reset asserted while a write is buffered and a read is in flight -> all outputs 0 asynchronously; ram_w2 never pulses; no valid strobe after release.
